// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program-flow controller: flow-control opcodes
// (also consumed by the ICU, which treats them as datapath NOPs) and sequencer states.
package prog_sequencer_pkg;

  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JSR = 4'hD;
  localparam logic [3:0] OP_RTN = 4'hE;
  localparam logic [3:0] OP_SKZ = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/prog_sequencer_next_addr_gen.sv
// Combinational next-address, skip and return-register logic for the sequencer.
// Nothing changes unless the sequencer is in an active (RUN/STEP) cycle.
module next_addr_gen
  import prog_sequencer_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic          active,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] ret,
  input  logic          ret_valid,
  input  logic          skip_pending,
  input  logic [7:0]    instruction,
  input  logic          result,
  output logic [AW-1:0] addr_nxt,
  output logic [AW-1:0] ret_nxt,
  output logic          ret_valid_nxt,
  output logic          skip_nxt,
  output logic          exec_en
);

  logic [AW-1:0] addr_inc;
  logic [AW-1:0] target;
  logic          unused_instr;

  assign addr_inc     = addr + AW'(1);
  assign target       = instruction[AW-1:0];
  assign exec_en      = active & ~skip_pending;
  assign unused_instr = ^instruction;

  always_comb begin
    addr_nxt      = addr;
    ret_nxt       = ret;
    ret_valid_nxt = ret_valid;
    skip_nxt      = skip_pending;
    if (active) begin
      // A skipped slot only advances; its opcode, even a flow opcode, is discarded.
      if (skip_pending) begin
        addr_nxt = addr_inc;
        skip_nxt = 1'b0;
      end else begin
        case (instruction[7:4])
          OP_JMP: addr_nxt = target;
          OP_JSR: begin
            ret_nxt       = addr_inc;
            ret_valid_nxt = 1'b1;
            addr_nxt      = target;
          end
          OP_RTN: begin
            if (ret_valid) begin
              addr_nxt      = ret;
              ret_valid_nxt = 1'b0;
            end else begin
              addr_nxt = addr_inc;
            end
          end
          OP_SKZ: begin
            addr_nxt = addr_inc;
            skip_nxt = ~result;
          end
          default: addr_nxt = addr_inc;
        endcase
      end
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program-flow controller: run/halt/single-step FSM driving the ROM address and
// the ICU execute enable, with jump, one-level call/return and skip-if-zero.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          step,
  input  logic          halt_req,
  input  logic [7:0]    instruction,
  input  logic          result,
  output logic [AW-1:0] addr,
  output logic          exec_en,
  output logic          halted
);

  seq_state_e    state, state_nxt;
  logic [AW-1:0] ret, addr_nxt, ret_nxt;
  logic          ret_valid, ret_valid_nxt;
  logic          skip_pending, skip_nxt;
  logic          active;

  assign active = (state == ST_RUN) || (state == ST_STEP);
  assign halted = (state == ST_IDLE);

  next_addr_gen #(.AW(AW)) u_next_addr_gen (
    .active        (active),
    .addr          (addr),
    .ret           (ret),
    .ret_valid     (ret_valid),
    .skip_pending  (skip_pending),
    .instruction   (instruction),
    .result        (result),
    .addr_nxt      (addr_nxt),
    .ret_nxt       (ret_nxt),
    .ret_valid_nxt (ret_valid_nxt),
    .skip_nxt      (skip_nxt),
    .exec_en       (exec_en)
  );

  // halt_req has priority over run, run over step; step only matters from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (halt_req)  state_nxt = ST_IDLE;
        else if (run)  state_nxt = ST_RUN;
        else if (step) state_nxt = ST_STEP;
      end
      ST_RUN:  if (halt_req || !run) state_nxt = ST_IDLE;
      ST_STEP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr         <= '0;
      ret          <= '0;
      ret_valid    <= 1'b0;
      skip_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr         <= addr_nxt;
      ret          <= ret_nxt;
      ret_valid    <= ret_valid_nxt;
      skip_pending <= skip_nxt;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer (AW=4): directed programs with literal expectations
// plus randomized control/ROM traffic compared cycle by cycle against a reference model.
module tb_prog_sequencer;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0, step = 1'b0, halt_req = 1'b0, result = 1'b0;
  logic [7:0]    instruction;
  logic [AW-1:0] addr;
  logic          exec_en, halted;
  logic [7:0]    rom [DEPTH];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign instruction = rom[addr];

  prog_sequencer #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .instruction (instruction),
    .result      (result),
    .addr        (addr),
    .exec_en     (exec_en),
    .halted      (halted)
  );

  // Reference model: mode 0=idle, 1=running, 2=single step.
  int m_mode, m_addr, m_ret;
  bit m_rv, m_skip;
  int op, tgt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_addr <= 0; m_ret <= 0; m_rv <= 0; m_skip <= 0;
    end else begin
      if (m_mode != 0) begin
        if (m_skip) begin
          m_addr <= (m_addr + 1) % DEPTH;
          m_skip <= 0;
        end else begin
          op  = rom[m_addr] >> 4;
          tgt = rom[m_addr] % DEPTH;
          if (op == 12) m_addr <= tgt;
          else if (op == 13) begin
            m_ret <= (m_addr + 1) % DEPTH; m_rv <= 1; m_addr <= tgt;
          end else if (op == 14 && m_rv) begin
            m_addr <= m_ret; m_rv <= 0;
          end else begin
            m_addr <= (m_addr + 1) % DEPTH;
            if (op == 15 && !result) m_skip <= 1;
          end
        end
      end
      if (m_mode == 0)      m_mode <= halt_req ? 0 : run ? 1 : step ? 2 : 0;
      else if (m_mode == 1) m_mode <= (halt_req || !run) ? 0 : 1;
      else                  m_mode <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_addr", 32'(addr), 32'(m_addr));
      chk("model_exec_en", 32'(exec_en), 32'((m_mode != 0) && !m_skip));
      chk("model_halted", 32'(halted), 32'(m_mode == 0));
    end
  end

  task automatic lit(input int a, input int e, input int h);
    @(negedge clk);
    chk("lit_addr", 32'(addr), 32'(a));
    chk("lit_exec_en", 32'(exec_en), 32'(e));
    chk("lit_halted", 32'(halted), 32'(h));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    run = 0; step = 0; halt_req = 0;
    @(posedge clk);
    #2 rst = 1;
    #2 rst = 0;
  endtask

  task automatic start_run();
    @(posedge clk);
    #1 run = 1;
    @(posedge clk);
  endtask

  initial begin
    clear_rom();
    #12 rst = 0;
    // reset state, no run yet
    lit(0, 0, 1);
    lit(0, 0, 1);

    // jump: 0,1,2 -> 9,10
    clear_rom(); rom[2] = 8'hC9;
    start_run();
    lit(0, 1, 0); lit(1, 1, 0); lit(2, 1, 0); lit(9, 1, 0); lit(10, 1, 0);
    do_reset();

    // full sweep with jump at 15 back to 0
    clear_rom(); rom[15] = 8'hC0;
    start_run();
    for (int i = 0; i < DEPTH; i++) lit(i, 1, 0);
    lit(0, 1, 0); lit(1, 1, 0);
    do_reset();

    // call/return, then an RTN with no saved return acts as NOP
    clear_rom(); rom[1] = 8'hD8; rom[9] = 8'hE0; rom[3] = 8'hE0;
    start_run();
    lit(0, 1, 0); lit(1, 1, 0); lit(8, 1, 0); lit(9, 1, 0);
    lit(2, 1, 0); lit(3, 1, 0); lit(4, 1, 0);
    do_reset();

    // SKZ with result=0: slot 4 skipped, its JMP ignored
    clear_rom(); rom[3] = 8'hF0; rom[4] = 8'hC0; result = 0;
    start_run();
    lit(0, 1, 0); lit(1, 1, 0); lit(2, 1, 0); lit(3, 1, 0);
    lit(4, 0, 0); lit(5, 1, 0); lit(6, 1, 0);
    do_reset();

    // SKZ with result=1: no skip
    rom[4] = 8'h00; result = 1;
    start_run();
    lit(0, 1, 0); lit(1, 1, 0); lit(2, 1, 0); lit(3, 1, 0);
    lit(4, 1, 0); lit(5, 1, 0);
    do_reset();

    // halt at addr 5, then single steps, then step+halt together
    clear_rom();
    start_run();
    for (int i = 0; i < 5; i++) lit(i, 1, 0);
    lit(5, 1, 0);
    halt_req = 1;
    lit(6, 0, 1); lit(6, 0, 1);
    run = 0; halt_req = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 step = 1;
      @(posedge clk); #1 step = 0;
      lit(6 + k, 1, 0);
      lit(7 + k, 0, 1);
    end
    @(posedge clk); #1 step = 1; halt_req = 1;
    @(posedge clk); #1 step = 0; halt_req = 0;
    lit(8, 0, 1); lit(8, 0, 1);
    do_reset();

    // async reset mid-cycle at addr 7 with a saved return address
    clear_rom(); rom[1] = 8'hD6;
    start_run();
    lit(0, 1, 0); lit(1, 1, 0); lit(6, 1, 0); lit(7, 1, 0);
    #1 rst = 1;
    #1;
    chk("async_addr", 32'(addr), 32'd0);
    chk("async_halted", 32'(halted), 32'd1);
    chk("async_exec_en", 32'(exec_en), 32'd0);
    run = 0;
    #1 rst = 0;
    rom[0] = 8'hE0;
    start_run();
    lit(0, 1, 0); lit(1, 1, 0);
    do_reset();

    // randomized control and programs against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++)
          rom[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255) & 8'hBF)
                                               : 8'({4'($urandom_range(12, 15)), 4'($urandom_range(0, 15))});
      end
      @(posedge clk); #1;
      if ($urandom_range(0, 19) == 0) run = ~run;
      halt_req = ($urandom_range(0, 14) == 0);
      step     = ($urandom_range(0, 5) == 0);
      result   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1;
        #1 rst = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
